// File: rtl/request_issue_queue.sv
// FIFO issue queue feeding pipeline_stage; absorbs requester bursts and honours stall.
// Optional zero-latency empty-queue bypass is enabled by defining ISSUE_QUEUE_BYPASS_EN.

module request_issue_queue_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Payload storage only; validity comes from the queue pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (we) q <= d;
  end
endmodule

module request_issue_queue #(
  parameter int DEPTH         = 4,
  parameter int AF_LEVEL      = 3,
  parameter int ADDRESS_WIDTH = 32,
  parameter int ID_WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDRESS_WIDTH-1:0]   in_address,
  input  logic [ID_WIDTH-1:0]        in_id,
  input  logic                       in_valid,
  output logic                       out_stall,
  output logic [ADDRESS_WIDTH-1:0]   out_address,
  output logic [ID_WIDTH-1:0]        out_id,
  output logic                       out_valid,
  input  logic                       in_stall,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic                       overflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] address;
    logic [ID_WIDTH-1:0]      id;
  } entry_t;
  localparam int EW = $bits(entry_t);

  logic [AW:0]               wr_ptr, rd_ptr;
  logic [AW-1:0]             wr_idx, rd_idx;
  logic [DEPTH-1:0][EW-1:0]  slot_q;
  logic [DEPTH-1:0]          slot_we;
  entry_t                    in_entry, head, out_entry;
  logic                      full, empty, bypass, push, pop;

  assign wr_idx   = wr_ptr[AW-1:0];
  assign rd_idx   = rd_ptr[AW-1:0];
  assign in_entry = '{address: in_address, id: in_id};
  assign head     = entry_t'(slot_q[rd_idx]);

  // Wrap bit distinguishes full from empty when indices coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

`ifdef ISSUE_QUEUE_BYPASS_EN
  assign bypass = empty && in_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry accepted downstream this cycle never touches storage.
  assign push = in_valid && !full && !(bypass && !in_stall);
  assign pop  = !empty && !in_stall;

  assign level       = wr_ptr - rd_ptr;
  assign out_stall   = full;
  assign almost_full = (level >= LW'(AF_LEVEL));
  assign out_valid   = !empty || bypass;

  always_comb begin
    out_entry = '0;
    if (bypass)      out_entry = in_entry;
    else if (!empty) out_entry = head;
  end

  assign out_address = out_entry.address;
  assign out_id      = out_entry.id;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign slot_we[g] = push && (wr_idx == AW'(g));
    request_issue_queue_slot #(.W(EW)) u_slot (
      .clk (clk),
      .we  (slot_we[g]),
      .d   (in_entry),
      .q   (slot_q[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push)                  wr_ptr       <= wr_ptr + 1'b1;
      if (pop)                   rd_ptr       <= rd_ptr + 1'b1;
      if (in_valid && out_stall) overflow_err <= 1'b1;
    end
  end
endmodule
